// File: rtl/lfsr_bank_pkg.sv
// Shared constants and types for the lfsr_bank random source.
// Tap masks are stored 32 bits wide and trimmed to the channel width at the use site.
package lfsr_pkg;

    typedef enum logic {
        UNSEEDED = 1'b0,
        RUN      = 1'b1
    } bank_state_t;

    // Feedback taps: bits 15,14,12,3 for 16-bit channels, 31,21,1,0 for 32-bit channels
    localparam logic [31:0] TAP_MASK_16   = 32'h0000_D008;
    localparam logic [31:0] TAP_MASK_32   = 32'h8020_0003;

    localparam logic [31:0] ZERO_SEED_FIX = 32'h0000_0001;

endpackage

// File: rtl/rng_fifo.sv
// Small prefetch FIFO between the LFSR channels and the consumer.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module rng_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Head is forced to zero while empty so the output is clean after reset or a flush
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/lfsr_bank.sv
// Multi-channel Fibonacci LFSR bank feeding a prefetch FIFO with a valid/ready output.
// Each draw advances every channel NBITS bits and packs the low NBITS of each channel.
module lfsr_bank
    import lfsr_pkg::*;
#(
    parameter int NCH    = 3,
    parameter int LFSR_W = 16,
    parameter int NBITS  = 8,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    seed_load,
    input  logic [NCH*LFSR_W-1:0]   seed,
    output logic                    rnd_valid,
    input  logic                    rnd_ready,
    output logic [NCH*NBITS-1:0]    rnd,
    output logic                    seeded,
    output logic [31:0]             draw_cnt
);

    localparam int RW = NCH * NBITS;
    localparam logic [LFSR_W-1:0] TAP_MASK =
        (LFSR_W == 32) ? LFSR_W'(TAP_MASK_32) : LFSR_W'(TAP_MASK_16);

    bank_state_t    state_q;
    bank_state_t    state_d;
    logic           gen_en;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [RW-1:0]  entry;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        logic [LFSR_W-1:0] s;
        s = cur;
        for (int i = 0; i < NBITS; i++) begin
            s = {s[LFSR_W-2:0], ^(s & TAP_MASK)};
        end
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= UNSEEDED;
        else        state_q <= state_d;
    end

    // A seed load wins over generation: the write that would coincide with it is dropped
    always_comb begin
        state_d = state_q;
        seeded  = 1'b0;
        gen_en  = 1'b0;
        if (seed_load) state_d = RUN;
        case (state_q)
            UNSEEDED: begin
                seeded = 1'b0;
            end
            RUN: begin
                seeded = 1'b1;
                gen_en = !seed_load && (!fifo_full || pop);
            end
            default: begin
                seeded = 1'b0;
            end
        endcase
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [LFSR_W-1:0] lfsr_q;
        logic [LFSR_W-1:0] stepped;
        logic [LFSR_W-1:0] seed_k;

        assign seed_k  = seed[k*LFSR_W +: LFSR_W];
        assign stepped = lfsr_step(lfsr_q);
        assign entry[k*NBITS +: NBITS] = stepped[NBITS-1:0];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)          lfsr_q <= '0;
            else if (seed_load)  lfsr_q <= (seed_k == '0) ? LFSR_W'(ZERO_SEED_FIX) : seed_k;
            else if (gen_en)     lfsr_q <= stepped;
        end
    end

    assign rnd_valid = !fifo_empty;
    assign pop       = rnd_valid && rnd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         draw_cnt <= '0;
        else if (seed_load) draw_cnt <= '0;
        else if (pop)       draw_cnt <= draw_cnt + 32'd1;
    end

    rng_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (seed_load),
        .push  (gen_en),
        .pop   (pop),
        .wdata (entry),
        .rdata (rnd),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_lfsr_bank.sv
// Randomized self-checking bench for lfsr_bank in two configurations (3x16/8 and 2x32/16).
// The reference draws a bit-serial LFSR per channel and tracks FIFO occupancy as a counter.
module tb_lfsr_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        seed_load_a, ready_a, valid_a, seeded_a;
    logic [47:0] seed_a;
    logic [23:0] rnd_a;
    logic [31:0] cnt_a;

    logic        seed_load_b, ready_b, valid_b, seeded_b;
    logic [63:0] seed_b;
    logic [31:0] rnd_b;
    logic [31:0] cnt_b;

    lfsr_bank #(.NCH(3), .LFSR_W(16), .NBITS(8), .DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load_a), .seed(seed_a),
        .rnd_valid(valid_a), .rnd_ready(ready_a), .rnd(rnd_a),
        .seeded(seeded_a), .draw_cnt(cnt_a)
    );

    lfsr_bank #(.NCH(2), .LFSR_W(32), .NBITS(16), .DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load_b), .seed(seed_b),
        .rnd_valid(valid_b), .rnd_ready(ready_b), .rnd(rnd_b),
        .seeded(seeded_b), .draw_cnt(cnt_b)
    );

    int total = 0;
    int bad   = 0;
    int cfg   = 0;

    int          m_nch, m_w, m_nb;
    bit          m_run;
    int          m_occ;
    logic [31:0] m_cnt;
    logic [31:0] m_cons [3];

    logic        obs_valid, obs_seeded;
    logic [31:0] obs_rnd, obs_cnt;

    always_comb begin
        obs_valid  = valid_a;
        obs_seeded = seeded_a;
        obs_rnd    = {8'h00, rnd_a};
        obs_cnt    = cnt_a;
        if (cfg != 0) begin
            obs_valid  = valid_b;
            obs_seeded = seeded_b;
            obs_rnd    = rnd_b;
            obs_cnt    = cnt_b;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] refStep(input logic [31:0] s, input int w, input int nb);
        logic fb;
        for (int i = 0; i < nb; i++) begin
            if (w == 16) fb = s[15] ^ s[14] ^ s[12] ^ s[3];
            else         fb = s[31] ^ s[21] ^ s[1] ^ s[0];
            s = {s[30:0], fb};
            if (w == 16) s = s & 32'h0000_FFFF;
        end
        return s;
    endfunction

    task automatic modelDraw(output logic [31:0] d);
        logic [31:0] nbmask;
        nbmask = (m_nb == 32) ? 32'hFFFF_FFFF : ((32'h1 << m_nb) - 32'h1);
        d = '0;
        for (int k = 0; k < m_nch; k++) begin
            m_cons[k] = refStep(m_cons[k], m_w, m_nb);
            d = d | ((m_cons[k] & nbmask) << (k * m_nb));
        end
    endtask

    task automatic modelSeed(input logic [63:0] sd);
        logic [31:0] wmask;
        logic [31:0] s;
        wmask = (m_w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        for (int k = 0; k < m_nch; k++) begin
            s = 32'(sd >> (k * m_w)) & wmask;
            if (s == 32'h0) s = 32'h1;
            m_cons[k] = s;
        end
        m_occ = 0;
        m_cnt = '0;
        m_run = 1'b1;
    endtask

    task automatic modelReset();
        m_run = 1'b0;
        m_occ = 0;
        m_cnt = '0;
    endtask

    // One clock cycle: drive inputs, check the pre-edge outputs, advance the model, check post-edge
    task automatic applyStimulus(input bit load, input logic [63:0] sd, input bit rdy);
        logic        exp_valid;
        logic        pop;
        logic        push;
        logic [31:0] d;
        if (cfg == 0) begin
            seed_load_a = load; seed_a = sd[47:0]; ready_a = rdy;
        end else begin
            seed_load_b = load; seed_b = sd;       ready_b = rdy;
        end
        #1;
        exp_valid = (m_occ > 0);
        checkOutput("rnd_valid", {63'h0, obs_valid}, {63'h0, exp_valid});
        pop = exp_valid && rdy;
        if (pop) begin
            modelDraw(d);
            checkOutput("rnd", {32'h0, obs_rnd}, {32'h0, d});
        end
        if (load) begin
            modelSeed(sd);
        end else if (m_run) begin
            push  = (m_occ < 4) || pop;
            m_occ = m_occ - int'(pop) + int'(push);
            if (pop) m_cnt = m_cnt + 32'd1;
        end
        @(posedge clk);
        #1;
        checkOutput("seeded", {63'h0, obs_seeded}, {63'h0, m_run});
        checkOutput("draw_cnt", {32'h0, obs_cnt}, {32'h0, m_cnt});
    endtask

    initial begin
        logic [63:0] all_one_a;
        all_one_a = {16'h0, 16'h0001, 16'h0001, 16'h0001};

        rst_n = 1'b0;
        seed_load_a = 1'b0; seed_a = '0; ready_a = 1'b0;
        seed_load_b = 1'b0; seed_b = '0; ready_b = 1'b0;
        cfg = 0; m_nch = 3; m_w = 16; m_nb = 8;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rnd_a", {40'h0, rnd_a}, 64'h0);
        checkOutput("rst_valid_a", {63'h0, valid_a}, 64'h0);
        rst_n = 1'b1;

        $display("[TB] reset hold, no seed");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
            checkOutput("hold_rnd", {32'h0, obs_rnd}, 64'h0);
        end

        $display("[TB] seed 0001 on all channels, ready high");
        applyStimulus(1'b1, all_one_a, 1'b1);
        applyStimulus(1'b0, 64'h0, 1'b1);
        checkOutput("first_rnd", {32'h0, obs_rnd}, 64'h111111);
        for (int i = 0; i < 1000; i++) applyStimulus(1'b0, {$urandom(), $urandom()}, 1'b1);

        $display("[TB] zero-seed guard on channel 1");
        applyStimulus(1'b1, {16'h0, 16'h0001, 16'h0000, 16'h0001}, 1'b1);
        applyStimulus(1'b0, 64'h0, 1'b1);
        checkOutput("zero_guard_rnd", {32'h0, obs_rnd}, 64'h111111);
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 64'h0, 1'b1);

        $display("[TB] backpressure until full, then drain");
        applyStimulus(1'b1, all_one_a, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_rnd", {32'h0, obs_rnd}, 64'h111111);
            applyStimulus(1'b0, 64'h0, 1'b0);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 64'h0, 1'b1);

        $display("[TB] seed_load coincident with pop, three entries queued");
        applyStimulus(1'b1, {16'h0, 16'h1234, 16'hBEEF, 16'h0042}, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 64'h0, 1'b0);
        applyStimulus(1'b1, {16'h0, 16'h5A5A, 16'h0007, 16'hC001}, 1'b1);
        checkOutput("flush_cnt", {32'h0, obs_cnt}, 64'h0);
        applyStimulus(1'b0, 64'h0, 1'b1);
        applyStimulus(1'b0, 64'h0, 1'b1);

        $display("[TB] random traffic, 16-bit config");
        for (int i = 0; i < 800; i++) begin
            applyStimulus(1'($urandom_range(0, 49) == 0), {$urandom(), $urandom()},
                          1'($urandom_range(0, 3) != 0));
        end

        $display("[TB] 32-bit config, seed ACE10001");
        seed_load_a = 1'b0; ready_a = 1'b0;
        cfg = 1; m_nch = 2; m_w = 32; m_nb = 16;
        modelReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 64'h0, 1'b1);
        applyStimulus(1'b1, {32'hACE1_0001, 32'hACE1_0001}, 1'b1);
        for (int i = 0; i < 500; i++) applyStimulus(1'b0, 64'h0, 1'($urandom_range(0, 3) != 0));

        $display("[TB] reset mid-stream");
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", {63'h0, valid_b}, 64'h0);
        checkOutput("midrst_seeded", {63'h0, seeded_b}, 64'h0);
        checkOutput("midrst_cnt", {32'h0, cnt_b}, 64'h0);
        checkOutput("midrst_rnd", {32'h0, rnd_b}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, {$urandom(), $urandom()}, 1'b1);
        applyStimulus(1'b1, {$urandom(), 32'h0}, 1'b1);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'($urandom_range(0, 29) == 0), {$urandom(), $urandom()},
                          1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
